// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared constants, state enum and segment decoder for multi_dice
//
// Purpose : LFSR seed and Galois tap mask, FSM state type, face-to-segment map.
// Ports   : none (package).

package dice_pkg;

  // Seed loaded on reset; any non-zero value keeps the LFSR out of its lock-up state.
  localparam logic [15:0] LFSR_SEED = 16'h00DA;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_ROLLING = 1'b1
  } state_t;

  // Segment pattern for a face value, bits g..a, active-high.
  function automatic logic [6:0] face_to_seg(input logic [3:0] face);
    logic [6:0] seg;
    case (face)
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111100;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/dice_lfsr16.sv
// rtl/dice_lfsr16.sv - free-running 16-bit Galois LFSR
//
// Purpose : pseudo-random source, advances one step on every non-reset clock.
// Ports   : i_clk   - clock, rising edge
//           RST     - asynchronous active-high reset, loads LFSR_SEED
//           o_state - current LFSR contents (value before the next step)

module dice_lfsr16
  import dice_pkg::*;
(
  input  logic        i_clk,
  input  logic        RST,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge i_clk or posedge RST) begin
    if (RST) begin
      r_state <= LFSR_SEED;
    end else begin
      r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/multi_dice.sv
// rtl/multi_dice.sv - N-die electronic dice with slowing roll animation
//
// Purpose : on ROLL, animates the dice with face updates whose spacing grows
//           by one cycle per update, from DIV_START until the divider reaches
//           DIV_END, then shows the final faces with DONE set.
// Ports   : i_clk - clock, rising edge
//           RST   - asynchronous active-high reset
//           ROLL  - level request to start/restart a roll
//           HOLD  - per-die hold, present only when DICE_HOLD_EN is defined
//           SEG   - 7-segment pattern per die, die i on [7i+6:7i], bit0 = seg a
//           BUSY  - high while the roll animates
//           DONE  - decimal point, high when the faces are final
// Macro   : DICE_HOLD_EN adds the HOLD input.

module multi_dice
  import dice_pkg::*;
#(
  parameter int N_DICE    = 2,
  parameter int FACES     = 6,
  parameter int DIV_START = 2,
  parameter int DIV_END   = 160
) (
  input  logic                  i_clk,
  input  logic                  RST,
  input  logic                  ROLL,
`ifdef DICE_HOLD_EN
  input  logic [N_DICE-1:0]     HOLD,
`endif
  output logic [7*N_DICE-1:0]   SEG,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [7:0] DIV_START_L = 8'(DIV_START);
  localparam logic [7:0] DIV_END_L   = 8'(DIV_END);
  localparam logic [3:0] FACES_L     = 4'(FACES);
  localparam logic [6:0] SEG_ONE     = face_to_seg(4'd1);

  // Maps a 3-bit raw value onto 1..FACES. One subtraction gives r-FACES+1;
  // the extra passes only matter for FACES < 4, where a single wrap would
  // still leave the value above FACES.
  function automatic logic [3:0] raw_to_face(input logic [2:0] raw);
    logic [3:0] v;
    v = {1'b0, raw};
    for (int k = 0; k < 4; k++) begin
      if (v >= FACES_L) v = v - FACES_L;
    end
    return v + 4'd1;
  endfunction

  logic [15:0]          w_lfsr;
  logic [N_DICE-1:0]    w_hold;
  logic [7*N_DICE-1:0]  w_seg_next;
  logic [7:0]           w_cnt_inc;
  logic [7:0]           w_div_inc;
  logic                 w_unused_lfsr;

  state_t               r_state;
  logic [7:0]           r_cnt;
  logic [7:0]           r_div;
  logic [7*N_DICE-1:0]  r_seg;
  logic                 r_busy;
  logic                 r_done;

  dice_lfsr16 u_lfsr (
    .i_clk   (i_clk),
    .RST     (RST),
    .o_state (w_lfsr)
  );

`ifdef DICE_HOLD_EN
  assign w_hold = HOLD;
`else
  assign w_hold = '0;
`endif

  // Only three bits per die are consumed; the rest of the LFSR is left over.
  assign w_unused_lfsr = ^w_lfsr;

  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_div_inc = r_div + 8'd1;

  // Candidate segment word for this edge's face update; held dice keep their pattern.
  always_comb begin
    w_seg_next = r_seg;
    for (int i = 0; i < N_DICE; i++) begin
      if (!w_hold[i]) begin
        w_seg_next[7*i +: 7] = face_to_seg(raw_to_face(w_lfsr[4*i +: 3]));
      end
    end
  end

  always_ff @(posedge i_clk or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_div   <= DIV_END_L;
      r_seg   <= {N_DICE{SEG_ONE}};
      r_busy  <= 1'b0;
      r_done  <= 1'b1;
    end else if (ROLL) begin
      // A request wins over any update due on the same edge.
      r_state <= ST_ROLLING;
      r_cnt   <= 8'd0;
      r_div   <= DIV_START_L;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_ROLLING: begin
          if (w_cnt_inc == r_div) begin
            r_seg <= w_seg_next;
            r_cnt <= 8'd0;
            r_div <= w_div_inc;
            if (w_div_inc == DIV_END_L) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign SEG  = r_seg;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_multi_dice.sv
// tb/tb_multi_dice.sv - directed table-driven bench for multi_dice

module tb_multi_dice;

  typedef struct {
    bit roll;
    bit busy;
    bit done;
    bit upd;
  } vec_t;

  vec_t        tv[$];
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        roll = 1'b0;
  logic [1:0]  hold = 2'b00;
  logic [13:0] seg;
  logic        busy;
  logic        done;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [13:0] exp_seg;
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;
  bit          seen [2][7];

  always #5 clk = ~clk;

  multi_dice #(
    .N_DICE    (2),
    .FACES     (6),
    .DIV_START (2),
    .DIV_END   (5)
  ) dut (
    .i_clk (clk),
    .RST   (rst),
    .ROLL  (roll),
`ifdef DICE_HOLD_EN
    .HOLD  (hold),
`endif
    .SEG   (seg),
    .BUSY  (busy),
    .DONE  (done)
  );

  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[15] = n[15] ^ 1'b1;
      n[13] = n[13] ^ 1'b1;
      n[12] = n[12] ^ 1'b1;
      n[10] = n[10] ^ 1'b1;
    end
    return n;
  endfunction

  // Reference LFSR; m_prev is the value the DUT used at the most recent edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 16'h00DA;
      m_prev <= 16'h00DA;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= m_step(m_lfsr);
    end
  end

  function automatic logic [6:0] seg_of(input int f);
    case (f)
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7C;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] model_seg(input logic [13:0] cur, input logic [15:0] prev,
                                            input logic [1:0] h);
    logic [13:0] r;
    int raw;
    int f;
    r = cur;
    for (int i = 0; i < 2; i++) begin
      raw = int'(prev[4*i +: 3]);
      f = (raw < 6) ? raw + 1 : raw - 5;
      if (!h[i]) r[7*i +: 7] = seg_of(f);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic eb, input logic ed, input logic [13:0] es);
    n_vec++;
    if ({busy, done, seg} !== {eb, ed, es}) begin
      n_bad++;
      $display("FAIL %s: got busy=%0b done=%0b seg=%h, want busy=%0b done=%0b seg=%h",
               name, busy, done, seg, eb, ed, es);
    end
  endtask

  task automatic add_n(input int n, input bit r, input bit b, input bit d, input bit u);
    vec_t v;
    v.roll = r; v.busy = b; v.done = d; v.upd = u;
    for (int i = 0; i < n; i++) tv.push_back(v);
  endtask

  task automatic apply(input int i);
    roll = tv[i].roll;
    @(posedge clk);
    @(negedge clk);
    if (tv[i].upd) exp_seg = model_seg(exp_seg, m_prev, hold);
    check($sformatf("vec%0d", i), tv[i].busy, tv[i].done, exp_seg);
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(i);
    roll = 1'b0;
  endtask

  task automatic do_reset(input string name);
    #1 rst = 1'b1;
    #1;
    exp_seg = {7'h06, 7'h06};
    check(name, 1'b0, 1'b1, exp_seg);
    rst = 1'b0;
  endtask

  initial begin
    // A: single-cycle roll, updates at 2, 5, 9 (indices 0..11)
    add_n(1, 1, 1, 0, 0);
    add_n(1, 0, 1, 0, 0);
    add_n(1, 0, 1, 0, 1);
    add_n(2, 0, 1, 0, 0);
    add_n(1, 0, 1, 0, 1);
    add_n(3, 0, 1, 0, 0);
    add_n(1, 0, 0, 1, 1);
    add_n(2, 0, 0, 1, 0);
    // B: restart at cycle 4, updates at 2, 6, 9, 13 (indices 12..26)
    add_n(1, 1, 1, 0, 0);
    add_n(1, 0, 1, 0, 0);
    add_n(1, 0, 1, 0, 1);
    add_n(1, 0, 1, 0, 0);
    add_n(1, 1, 1, 0, 0);
    add_n(1, 0, 1, 0, 0);
    add_n(1, 0, 1, 0, 1);
    add_n(2, 0, 1, 0, 0);
    add_n(1, 0, 1, 0, 1);
    add_n(3, 0, 1, 0, 0);
    add_n(1, 0, 0, 1, 1);
    add_n(1, 0, 0, 1, 0);
    // C: ROLL held five cycles, no updates until released (indices 27..41)
    add_n(5, 1, 1, 0, 0);
    add_n(1, 0, 1, 0, 0);
    add_n(1, 0, 1, 0, 1);
    add_n(2, 0, 1, 0, 0);
    add_n(1, 0, 1, 0, 1);
    add_n(3, 0, 1, 0, 0);
    add_n(1, 0, 0, 1, 1);
    add_n(1, 0, 0, 1, 0);

    do_reset("reset");
    @(negedge clk);
    apply_range(0, 11);
    apply_range(12, 26);
    apply_range(27, 41);

    // Reset in the middle of a roll, then normal timing again.
    roll = 1'b1;
    @(posedge clk);
    @(negedge clk);
    roll = 1'b0;
    repeat (3) @(negedge clk);
    do_reset("midroll_reset");
    apply_range(0, 11);

    // Range and coverage over many short rolls.
    for (int n = 0; n < 2000; n++) begin
      bit ok;
      @(negedge clk);
      roll = 1'b1;
      @(negedge clk);
      roll = 1'b0;
      repeat (9) @(negedge clk);
      n_vec++;
      ok = (busy === 1'b0) && (done === 1'b1);
      for (int d = 0; d < 2; d++) begin
        bit legal;
        legal = 1'b0;
        for (int f = 1; f <= 6; f++) begin
          if (seg[7*d +: 7] === seg_of(f)) begin
            legal = 1'b1;
            seen[d][f] = 1'b1;
          end
        end
        ok = ok && legal;
      end
      if (!ok) begin
        n_bad++;
        $display("FAIL range roll%0d: got busy=%0b done=%0b seg=%h, want idle with faces 1..6",
                 n, busy, done, seg);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      for (int f = 1; f <= 6; f++) begin
        n_vec++;
        if (!seen[d][f]) begin
          n_bad++;
          $display("FAIL cover die%0d face%0d: got unseen, want seen", d, f);
        end
      end
    end

`ifdef DICE_HOLD_EN
    @(negedge clk);
    do_reset("hold_reset");
    hold = 2'b01;
    apply_range(0, 11);
    n_vec++;
    if (seg[6:0] !== 7'h06) begin
      n_bad++;
      $display("FAIL hold_die0: got %h, want %h", seg[6:0], 7'h06);
    end
    hold = 2'b00;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
